// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jr hazard sequencer: holds the front end while a load result is
// still on its way to ID, then checks the BTB prediction and flushes on a miss.
module branch_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        Branch,
  input  logic        Jr,
  input  logic [4:0]  ID_EX_RegDst,
  input  logic [4:0]  EX_MEM_RegDst,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemRead,
  input  logic        BranchTaken,
  input  logic        PredTaken,
  input  logic        PredTargetOk,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        Redirect,
  output logic        BTBUpdate,
  output logic [15:0] StallCycles,
  output logic [15:0] Mispredicts
);

  typedef enum logic [1:0] {RUN, WAIT1, UPD} state_t;

  state_t state, next_state;
  logic   use_rs, use_rt, load_ex, load_mem, mispredict, resolve_miss;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic ur, input logic ut);
    return (dst != 5'd0) && ((ur && dst == rs) || (ut && dst == rt));
  endfunction

  assign use_rs   = Branch | Jr;
  assign use_rt   = Branch;
  assign load_ex  = ID_EX_MemRead & ID_EX_RegWrite &
                    src_hit(ID_EX_RegDst, IF_ID_RegisterRs, IF_ID_RegisterRt, use_rs, use_rt);
  assign load_mem = EX_MEM_MemRead & EX_MEM_RegWrite &
                    src_hit(EX_MEM_RegDst, IF_ID_RegisterRs, IF_ID_RegisterRt, use_rs, use_rt);

  assign mispredict = Branch ? ((BranchTaken != PredTaken) |
                                (BranchTaken & PredTaken & ~PredTargetOk))
                             : (~PredTaken | ~PredTargetOk);

  // The detecting cycle is itself the first stall; a load in EX needs one more held
  // cycle (WAIT1), a load in MEM needs none, so RUN simply re-checks next cycle.
  always_comb begin
    next_state   = RUN;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Redirect     = 1'b0;
    resolve_miss = 1'b0;
    case (state)
      WAIT1: begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        next_state   = RUN;
      end
      default: begin
        if (load_ex || load_mem) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          next_state   = load_ex ? WAIT1 : RUN;
        end else if ((Branch || Jr) && mispredict) begin
          IF_ID_Flush  = 1'b1;
          Redirect     = 1'b1;
          resolve_miss = 1'b1;
          next_state   = UPD;
        end
      end
    endcase
  end

  assign BTBUpdate = (state == UPD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      StallCycles <= 16'd0;
      Mispredicts <= 16'd0;
    end else begin
      state <= next_state;
      if (ID_EX_Bubble) StallCycles <= sat_inc(StallCycles);
      if (resolve_miss) Mispredicts <= sat_inc(Mispredicts);
    end
  end

endmodule
